tm_queue_depth: RTL and testbench

Per-queue depth tracker for the traffic manager's first-level queues; the responder side of the linked-list manager's depth enqueue/dequeue request protocol. For every enqueue it reports whether the queue was empty; for every dequeue it reports whether at least one descriptor remains. The linked-list manager uses these flags to decide its head, tail and next-pointer writes. Depth is stored as per-queue enqueue/dequeue counters in block RAM, with a fixed-latency read-modify-write pipeline.

---
 rtl/tm_queue_depth.sv | 227 ++++++++++++++++++++++
 tb/tb_tm_queue_depth.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tm_queue_depth.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tm_queue_depth : per-queue depth tracker (enq/dequeue counters in RAM),  |
// |                  3-cycle read-modify-write pipeline with full forwarding |
// | Optional feature: TM_QUEUE_DEPTH_THRESHOLD_EN (enqueue threshold flag)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef FIRST_LVL_QUEUE_ID_NBITS
`define FIRST_LVL_QUEUE_ID_NBITS 4
`endif

module ram_1r1w #(
  parameter int WIDTH = 5,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] rdata_q;

  // Read-during-write to the same address returns the old contents.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module tm_queue_depth #(
  parameter int QID_NBITS   = `FIRST_LVL_QUEUE_ID_NBITS,
  parameter int DEPTH_NBITS = QID_NBITS + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 depth_enq_req,
  input  logic [QID_NBITS-1:0] depth_enq_qid,
  input  logic                 depth_deq_req,
  input  logic [QID_NBITS-1:0] depth_deq_qid,
  input  logic [QID_NBITS:0]   queue_threshold,
  output logic                 depth_enq_ack,
  output logic                 depth_enq_to_empty,
  output logic                 depth_enq_over_thr,
  output logic                 depth_deq_ack,
  output logic                 depth_deq_from_emptyp2,
  output logic                 init_done,
  output logic [1:0]           err
);
  localparam logic [QID_NBITS-1:0]   QID_ONE = QID_NBITS'(1);
  localparam logic [DEPTH_NBITS-1:0] CNT_ONE = DEPTH_NBITS'(1);
  localparam logic [DEPTH_NBITS-1:0] CNT_TWO = DEPTH_NBITS'(2);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [QID_NBITS-1:0]   sweep_q, sweep_d;
  logic                   init_we;
  logic                   init_done_q;
  logic [1:0]             err_q;

  // Enqueue pipeline: s1 (RAM read), s2 (compute), wr (ack + RAM write), dly (last write)
  logic                   e1_v_q, e2_v_q, ewr_v_q, edly_v_q;
  logic [QID_NBITS-1:0]   e1_qid_q, e2_qid_q, ewr_qid_q, edly_qid_q;
  logic [DEPTH_NBITS-1:0] e2_e_q, e2_d_q, ewr_cnt_q, edly_cnt_q;
  logic                   enq_te_q, enq_ot_q;
  // Dequeue pipeline, same stages; dwr_v_q is the D write enable, deq_ack_q the ack
  logic                   d1_v_q, d2_v_q, dwr_v_q, ddly_v_q, deq_ack_q, deq_p2_q;
  logic [QID_NBITS-1:0]   d1_qid_q, d2_qid_q, dwr_qid_q, ddly_qid_q;
  logic [DEPTH_NBITS-1:0] d2_e_q, d2_d_q, dwr_cnt_q, ddly_cnt_q;

  logic [DEPTH_NBITS-1:0] ea_rd, eb_rd, da_rd, db_rd;
  logic                   e_we, d_we;
  logic [QID_NBITS-1:0]   e_waddr, d_waddr;
  logic [DEPTH_NBITS-1:0] e_wdata, d_wdata;

  logic [DEPTH_NBITS-1:0] e1_e, e1_d, d1_e, d1_d;
  logic [DEPTH_NBITS-1:0] e2_e_f, e2_d_f, d2_e_f, d2_d_f;
  logic [DEPTH_NBITS-1:0] enq_depth, enq_cnt_new, deq_depth, deq_cnt_new;
  logic                   deq_ok, enq_over;

  function automatic logic [DEPTH_NBITS-1:0] fwd(
    input logic [DEPTH_NBITS-1:0] cur,
    input logic [QID_NBITS-1:0]   qid,
    input logic                   v,
    input logic [QID_NBITS-1:0]   wqid,
    input logic [DEPTH_NBITS-1:0] wcnt
  );
    return (v && (wqid == qid)) ? wcnt : cur;
  endfunction

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        sweep_d = sweep_q + QID_ONE;
        if (sweep_q == '1) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  assign e_we    = init_we | ewr_v_q;
  assign e_waddr = init_we ? sweep_q : ewr_qid_q;
  assign e_wdata = init_we ? '0 : ewr_cnt_q;
  assign d_we    = init_we | dwr_v_q;
  assign d_waddr = init_we ? sweep_q : dwr_qid_q;
  assign d_wdata = init_we ? '0 : dwr_cnt_q;

  ram_1r1w #(.WIDTH(DEPTH_NBITS), .AW(QID_NBITS)) u_ram_ea (
    .clk(clk), .we_i(e_we), .waddr_i(e_waddr), .wdata_i(e_wdata),
    .raddr_i(depth_enq_qid), .rdata_o(ea_rd));
  ram_1r1w #(.WIDTH(DEPTH_NBITS), .AW(QID_NBITS)) u_ram_eb (
    .clk(clk), .we_i(e_we), .waddr_i(e_waddr), .wdata_i(e_wdata),
    .raddr_i(depth_deq_qid), .rdata_o(eb_rd));
  ram_1r1w #(.WIDTH(DEPTH_NBITS), .AW(QID_NBITS)) u_ram_da (
    .clk(clk), .we_i(d_we), .waddr_i(d_waddr), .wdata_i(d_wdata),
    .raddr_i(depth_enq_qid), .rdata_o(da_rd));
  ram_1r1w #(.WIDTH(DEPTH_NBITS), .AW(QID_NBITS)) u_ram_db (
    .clk(clk), .we_i(d_we), .waddr_i(d_waddr), .wdata_i(d_wdata),
    .raddr_i(depth_deq_qid), .rdata_o(db_rd));

  // RAM data misses the writes of the three older requests; s1 patches the two
  // oldest (dly, wr) and s2 patches the newest once it has reached wr.
  assign e1_e = fwd(fwd(ea_rd, e1_qid_q, edly_v_q, edly_qid_q, edly_cnt_q),
                    e1_qid_q, ewr_v_q, ewr_qid_q, ewr_cnt_q);
  assign e1_d = fwd(fwd(da_rd, e1_qid_q, ddly_v_q, ddly_qid_q, ddly_cnt_q),
                    e1_qid_q, dwr_v_q, dwr_qid_q, dwr_cnt_q);
  assign d1_e = fwd(fwd(eb_rd, d1_qid_q, edly_v_q, edly_qid_q, edly_cnt_q),
                    d1_qid_q, ewr_v_q, ewr_qid_q, ewr_cnt_q);
  assign d1_d = fwd(fwd(db_rd, d1_qid_q, ddly_v_q, ddly_qid_q, ddly_cnt_q),
                    d1_qid_q, dwr_v_q, dwr_qid_q, dwr_cnt_q);

  assign e2_e_f      = fwd(e2_e_q, e2_qid_q, ewr_v_q, ewr_qid_q, ewr_cnt_q);
  assign e2_d_f      = fwd(e2_d_q, e2_qid_q, dwr_v_q, dwr_qid_q, dwr_cnt_q);
  assign enq_depth   = e2_e_f - e2_d_f;
  assign enq_cnt_new = e2_e_f + CNT_ONE;

  // A same-cycle enqueue is ordered ahead of the dequeue, so its new count wins.
  assign d2_e_f      = fwd(fwd(d2_e_q, d2_qid_q, ewr_v_q, ewr_qid_q, ewr_cnt_q),
                           d2_qid_q, e2_v_q, e2_qid_q, enq_cnt_new);
  assign d2_d_f      = fwd(d2_d_q, d2_qid_q, dwr_v_q, dwr_qid_q, dwr_cnt_q);
  assign deq_depth   = d2_e_f - d2_d_f;
  assign deq_cnt_new = d2_d_f + CNT_ONE;
  assign deq_ok      = d2_v_q && (deq_depth != '0);

`ifdef TM_QUEUE_DEPTH_THRESHOLD_EN
  assign enq_over = (enq_depth >= queue_threshold);
`else
  logic unused_thr;
  assign unused_thr = ^queue_threshold;
  assign enq_over   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      err_q       <= '0;
      e1_v_q <= 1'b0; e1_qid_q <= '0;
      e2_v_q <= 1'b0; e2_qid_q <= '0; e2_e_q <= '0; e2_d_q <= '0;
      ewr_v_q <= 1'b0; ewr_qid_q <= '0; ewr_cnt_q <= '0;
      enq_te_q <= 1'b0; enq_ot_q <= 1'b0;
      edly_v_q <= 1'b0; edly_qid_q <= '0; edly_cnt_q <= '0;
      d1_v_q <= 1'b0; d1_qid_q <= '0;
      d2_v_q <= 1'b0; d2_qid_q <= '0; d2_e_q <= '0; d2_d_q <= '0;
      dwr_v_q <= 1'b0; dwr_qid_q <= '0; dwr_cnt_q <= '0;
      deq_ack_q <= 1'b0; deq_p2_q <= 1'b0;
      ddly_v_q <= 1'b0; ddly_qid_q <= '0; ddly_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= (state_q == ST_RUN);
      err_q[0]    <= err_q[0] | (d2_v_q && (deq_depth == '0));
      err_q[1]    <= err_q[1] | ((depth_enq_req | depth_deq_req) & ~init_done_q);

      e1_v_q     <= depth_enq_req & init_done_q;
      e1_qid_q   <= depth_enq_qid;
      e2_v_q     <= e1_v_q;
      e2_qid_q   <= e1_qid_q;
      e2_e_q     <= e1_e;
      e2_d_q     <= e1_d;
      ewr_v_q    <= e2_v_q;
      ewr_qid_q  <= e2_qid_q;
      ewr_cnt_q  <= enq_cnt_new;
      enq_te_q   <= e2_v_q && (enq_depth == '0);
      enq_ot_q   <= e2_v_q && enq_over;
      edly_v_q   <= ewr_v_q;
      edly_qid_q <= ewr_qid_q;
      edly_cnt_q <= ewr_cnt_q;

      d1_v_q     <= depth_deq_req & init_done_q;
      d1_qid_q   <= depth_deq_qid;
      d2_v_q     <= d1_v_q;
      d2_qid_q   <= d1_qid_q;
      d2_e_q     <= d1_e;
      d2_d_q     <= d1_d;
      dwr_v_q    <= deq_ok;
      dwr_qid_q  <= d2_qid_q;
      dwr_cnt_q  <= deq_cnt_new;
      deq_ack_q  <= d2_v_q;
      deq_p2_q   <= d2_v_q && (deq_depth >= CNT_TWO);
      ddly_v_q   <= dwr_v_q;
      ddly_qid_q <= dwr_qid_q;
      ddly_cnt_q <= dwr_cnt_q;
    end
  end

  assign depth_enq_ack          = ewr_v_q;
  assign depth_enq_to_empty     = enq_te_q;
  assign depth_enq_over_thr     = enq_ot_q;
  assign depth_deq_ack          = deq_ack_q;
  assign depth_deq_from_emptyp2 = deq_p2_q;
  assign init_done              = init_done_q;
  assign err                    = err_q;
endmodule
`default_nettype wire

// File: tb/tb_tm_queue_depth.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for tm_queue_depth (QID_NBITS=4): directed request sequences
// checked 3 cycles later against hand values or a simple per-queue depth model.
module tb_tm_queue_depth;
  localparam int THR = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       depth_enq_req = 1'b0;
  logic [3:0] depth_enq_qid = '0;
  logic       depth_deq_req = 1'b0;
  logic [3:0] depth_deq_qid = '0;
  logic [4:0] queue_threshold = 5'(THR);
  logic       depth_enq_ack, depth_enq_to_empty, depth_enq_over_thr;
  logic       depth_deq_ack, depth_deq_from_emptyp2, init_done;
  logic [1:0] err;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int depth_m [16];
  bit ev_q [3], ete_q [3], eot_q [3], dv_q [3], dp2_q [3];

  tm_queue_depth #(.QID_NBITS(4)) dut (
    .clk(clk), .rstn(rstn),
    .depth_enq_req(depth_enq_req), .depth_enq_qid(depth_enq_qid),
    .depth_deq_req(depth_deq_req), .depth_deq_qid(depth_deq_qid),
    .queue_threshold(queue_threshold),
    .depth_enq_ack(depth_enq_ack), .depth_enq_to_empty(depth_enq_to_empty),
    .depth_enq_over_thr(depth_enq_over_thr), .depth_deq_ack(depth_deq_ack),
    .depth_deq_from_emptyp2(depth_deq_from_emptyp2),
    .init_done(init_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One cycle: check the acks due now, then issue new requests.
  // xte/xp2 >= 0 give hand-computed flags; -1 takes the value from the model.
  task automatic step(input bit en, input int eq, input bit dn, input int dq,
                      input int xte, input int xp2);
    int s, dep;
    bit ev, ete, eot, dv, dp2;
    @(negedge clk);
    cyc++;
    s = cyc % 3;
    chk("enq_ack", 32'(depth_enq_ack), 32'(ev_q[s]));
    if (ev_q[s]) begin
      chk("enq_to_empty", 32'(depth_enq_to_empty), 32'(ete_q[s]));
      chk("enq_over_thr", 32'(depth_enq_over_thr), 32'(eot_q[s]));
    end
    chk("deq_ack", 32'(depth_deq_ack), 32'(dv_q[s]));
    if (dv_q[s]) chk("deq_from_emptyp2", 32'(depth_deq_from_emptyp2), 32'(dp2_q[s]));
    ev = 0; ete = 0; eot = 0; dv = 0; dp2 = 0;
    if (en && cyc >= 17) begin
      dep = depth_m[eq];
      ev  = 1;
      ete = (dep == 0);
`ifdef TM_QUEUE_DEPTH_THRESHOLD_EN
      eot = (dep >= THR);
`endif
      depth_m[eq] = dep + 1;
      if (xte >= 0) ete = (xte != 0);
    end
    if (dn && cyc >= 17) begin
      dep = depth_m[dq];
      dv  = 1;
      dp2 = (dep >= 2);
      if (dep > 0) depth_m[dq] = dep - 1;
      if (xp2 >= 0) dp2 = (xp2 != 0);
    end
    ev_q[s] = ev; ete_q[s] = ete; eot_q[s] = eot; dv_q[s] = dv; dp2_q[s] = dp2;
    depth_enq_req = en; depth_enq_qid = 4'(eq);
    depth_deq_req = dn; depth_deq_qid = 4'(dq);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, -1, -1);
  endtask

  task automatic drain(input int q);
    for (int i = 0; i < 40 && depth_m[q] > 0; i++) step(0, 0, 1, q, -1, -1);
  endtask

  task automatic restart();
    for (int i = 0; i < 3; i++) begin
      ev_q[i] = 0; ete_q[i] = 0; eot_q[i] = 0; dv_q[i] = 0; dp2_q[i] = 0;
    end
    for (int q = 0; q < 16; q++) depth_m[q] = 0;
    @(negedge clk);
    rstn = 1'b1;
    cyc  = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int q = 0; q < 16; q++) depth_m[q] = 0;
    repeat (3) @(negedge clk);
    chk("rst_enq_ack", 32'(depth_enq_ack), 32'd0);
    chk("rst_to_empty", 32'(depth_enq_to_empty), 32'd0);
    chk("rst_over_thr", 32'(depth_enq_over_thr), 32'd0);
    chk("rst_deq_ack", 32'(depth_deq_ack), 32'd0);
    chk("rst_emptyp2", 32'(depth_deq_from_emptyp2), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Init sweep; enqueue on qid 3 at cycle 5 is dropped and flagged
    restart();
    for (int k = 1; k <= 20; k++) begin
      step(k == 5, 3, 0, 0, -1, -1);
      if (k == 7)  chk("err_init_req", 32'(err), 32'd2);
      if (k == 16) chk("init_done_c16", 32'(init_done), 32'd0);
      if (k == 17) chk("init_done_c17", 32'(init_done), 32'd1);
    end

    // Back-to-back enqueues to qid 5
    step(1, 5, 0, 0, 1, -1);
    step(1, 5, 0, 0, 0, -1);
    step(1, 5, 0, 0, 0, -1);

    // Simultaneous enq/deq on qid 7 at depth 1 and at depth 0
    step(1, 7, 0, 0, 1, -1);
    step(1, 7, 1, 7, 0, 1);
    step(0, 0, 1, 7, -1, 0);
    step(1, 7, 1, 7, 1, 0);
    idle(3);
    chk("err_after_qid7", 32'(err), 32'd2);

    // Drain qid 5, then dequeue from empty
    step(0, 0, 1, 5, -1, 1);
    step(0, 0, 1, 5, -1, 1);
    step(0, 0, 1, 5, -1, 0);
    step(0, 0, 1, 5, -1, 0);
    idle(3);
    chk("err_deq_empty", 32'(err), 32'd3);
    step(1, 5, 0, 0, 1, -1);

    // Mixed traffic across all queues against the depth model
    for (int i = 0; i < 40; i++) begin
      step(1, (i * 7) % 16,
           (i % 2 == 1) || (i % 4 == 2),
           (i % 2 == 1) ? ((i - 1) * 7) % 16 : (i * 7) % 16, -1, -1);
    end

    // Counter wrap on qid 1
    drain(1);
    for (int i = 0; i < 32; i++) begin
      step(1, 1, 0, 0, 1, -1);
      step(0, 0, 1, 1, -1, 0);
    end

    // Threshold flag on qid 9 (0,0,1 when the feature is built)
    drain(9);
    step(1, 9, 0, 0, 1, -1);
    step(1, 9, 0, 0, 0, -1);
    step(1, 9, 0, 0, 0, -1);
    idle(3);

    // Reset with requests in flight: no acks, RAMs cleared again
    step(1, 2, 0, 0, -1, -1);
    step(1, 2, 0, 0, -1, -1);
    @(negedge clk);
    rstn = 1'b0;
    depth_enq_req = 1'b0;
    depth_deq_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_enq_ack", 32'(depth_enq_ack), 32'd0);
      chk("midrst_deq_ack", 32'(depth_deq_ack), 32'd0);
    end
    chk("midrst_init_done", 32'(init_done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    restart();
    idle(17);
    step(1, 2, 0, 0, 1, -1);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
